// File: rtl/instr_loader.sv
// instr_loader: write side of instruction memory.
// Packs a serial byte stream (LSB first) into 32-bit little-endian words and
// writes them at consecutive word addresses starting at BASE_ADDR. The CPU is
// held from the accepted start until the load completes, so fetch never sees a
// partial image.
module instr_loader #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           MEM_SIZE   = 512,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [15:0]           word_count,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int unsigned      CNT_W        = 16;
  localparam logic [31:0]      MEM_SIZE_32  = 32'(MEM_SIZE);
  localparam logic [CNT_W-1:0] MEM_SIZE_CNT = CNT_W'(MEM_SIZE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Load bookkeeping.
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [CNT_W-1:0] word_idx_q, word_idx_d;
  logic [CNT_W-1:0] n_q, n_d;
  // The first three bytes of the word in flight; the fourth comes straight
  // from byte_data when the word is assembled.
  logic [2:0][7:0]  slot_q, slot_d;

  // Registered outputs.
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  overflow_q, overflow_d;

  // Handshake and start qualification.
  logic             byte_fire;
  logic             start_fire;
  logic             ovf_start;
  logic [CNT_W-1:0] n_start;
  logic             last_word;

  // byte_ready decodes the registered state, so it is glitch-free and known
  // to the source before the edge on which the byte is taken.
  assign byte_ready = (state_q == S_LOAD);
  assign byte_fire  = byte_valid & byte_ready;
  assign start_fire = start & (state_q == S_IDLE);

  // Clamp the requested length to the memory depth; this also bounds wr_addr
  // so it can never wrap past the last word.
  assign ovf_start  = ({16'b0, word_count} > MEM_SIZE_32);
  assign n_start    = ovf_start ? MEM_SIZE_CNT : word_count;
  assign last_word  = ((word_idx_q + 16'd1) == n_q);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first; a path that leaves it unassigned would infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_fire) begin
          state_d = (n_start != '0) ? S_LOAD : S_DONE;
        end
      end
      S_LOAD: begin
        if (byte_fire && (byte_idx_q == 2'd3)) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        state_d = last_word ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output and datapath next-values, derived from the current and next state.
  always_comb begin
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    n_d        = n_q;
    slot_d     = slot_q;
    overflow_d = overflow_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (start_fire) begin
      n_d        = n_start;
      overflow_d = ovf_start;
      word_idx_d = '0;
      byte_idx_d = '0;
    end

    if (byte_fire) begin
      byte_idx_d = byte_idx_q + 2'd1;
      unique case (byte_idx_q)
        2'd0: slot_d[0] = byte_data;
        2'd1: slot_d[1] = byte_data;
        2'd2: slot_d[2] = byte_data;
        default: begin
          // Fourth byte: assemble {b3,b2,b1,b0} and the address for WRITE.
          wr_data_d = {byte_data, slot_q[2], slot_q[1], slot_q[0]};
          wr_addr_d = BASE_ADDR + (ADDR_WIDTH'(word_idx_q) << 2);
        end
      endcase
    end

    if (state_q == S_WRITE) begin
      word_idx_d = word_idx_q + 16'd1;
      byte_idx_d = '0;
    end

    wr_en_d    = (state_d == S_WRITE);
    busy_d     = (state_d == S_LOAD) || (state_d == S_WRITE);
    cpu_hold_d = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  // Datapath and output registers; reset discards any partial word.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: the byte slots are reset too: a reset mid-load must discard the
      // partial word, and they are only a few flops, not a memory array.
      byte_idx_q <= '0;
      word_idx_q <= '0;
      n_q        <= '0;
      slot_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      cpu_hold_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      n_q        <= n_d;
      slot_q     <= slot_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      cpu_hold_q <= cpu_hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cpu_hold = cpu_hold_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed bench for instr_loader. A default instance (512
// words) and a small instance (4 words) share data inputs but have separate
// start pulses. Writes are collected at the falling edge into queues.
module tb_instr_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        start4;
  logic [15:0] word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;

  logic        byte_ready,  wr_en,  cpu_hold,  busy,  done,  overflow;
  logic [31:0] wr_addr,  wr_data;
  logic        byte_ready4, wr_en4, cpu_hold4, busy4, done4, overflow4;
  logic [31:0] wr_addr4, wr_data4;

  int checks = 0;
  int errors = 0;

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [31:0] wa4_q[$];
  logic [31:0] wd4_q[$];
  int          rdy_in_write = 0;

  logic [31:0] stim [0:15];

  instr_loader dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .overflow(overflow)
  );

  instr_loader #(.MEM_SIZE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready4),
    .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4), .cpu_hold(cpu_hold4),
    .busy(busy4), .done(done4), .overflow(overflow4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Collect memory writes away from the active edge.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
      if (byte_ready !== 1'b0) rdy_in_write++;
    end
    if (wr_en4 === 1'b1) begin
      wa4_q.push_back(wr_addr4);
      wd4_q.push_back(wr_data4);
      if (byte_ready4 !== 1'b0) rdy_in_write++;
    end
  end

  // Global time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    wa_q.delete();
    wd_q.delete();
    wa4_q.delete();
    wd4_q.delete();
  endtask

  task automatic pulse_start(input bit sel, input logic [15:0] cnt);
    word_count = cnt;
    if (sel) start4 = 1'b1;
    else     start  = 1'b1;
    tick();
    start  = 1'b0;
    start4 = 1'b0;
  endtask

  // Present one byte and hold it until accepted or the budget runs out.
  task automatic send_byte(input bit sel, input logic [7:0] b, input int budget, output bit ok);
    byte_valid = 1'b1;
    byte_data  = b;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((sel ? byte_ready4 : byte_ready) === 1'b1) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Stream stim[0..n-1] LSB first, optionally with random idle gaps.
  task automatic send_words(input bit sel, input int n, input bit gaps, output bit ok);
    bit b_ok;
    ok = 1'b1;
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 4; k++) begin
        if (gaps) begin
          int g;
          g = int'($urandom_range(0, 2));
          if (g != 0) begin
            byte_valid = 1'b0;
            repeat (g) tick();
          end
        end
        send_byte(sel, stim[w][8*k +: 8], 40, b_ok);
        if (!b_ok) begin
          ok = 1'b0;
          byte_valid = 1'b0;
          return;
        end
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((sel ? done4 : done) === 1'b1) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start4 = 1'b0; word_count = '0;
    byte_valid = 1'b0; byte_data = '0;
    repeat (3) tick();
    checks++; if ({byte_ready, wr_en, cpu_hold, busy, done, overflow} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 000000", {byte_ready, wr_en, cpu_hold, busy, done, overflow}); end
    checks++; if ({wr_addr, wr_data} !== 64'h0) begin
      errors++; $display("FAIL reset_bus got %h want 0", {wr_addr, wr_data}); end
    checks++; if ({byte_ready4, wr_en4, cpu_hold4, busy4, done4, overflow4} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl4 got %b want 000000", {byte_ready4, wr_en4, cpu_hold4, busy4, done4, overflow4}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    clear_queues();
    stim[0] = 32'h00500013;
    stim[1] = 32'h00100093;
    // First byte presented together with start: it must not be taken in IDLE.
    byte_valid = 1'b1;
    byte_data  = 8'h13;
    pulse_start(1'b0, 16'd2);
    checks++; if ({cpu_hold, busy, byte_ready, done, overflow} !== 5'b11100) begin
      errors++; $display("FAIL basic_start got %b want 11100", {cpu_hold, busy, byte_ready, done, overflow}); end
    send_words(1'b0, 2, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_accept got timeout want accepted"); end
    checks++; if ({wr_en, byte_ready} !== 2'b10) begin
      errors++; $display("FAIL basic_wr2 got %b want 10", {wr_en, byte_ready}); end
    checks++; if (wr_addr !== 32'h4 || wr_data !== 32'h00100093) begin
      errors++; $display("FAIL basic_wr2_bus got %h/%h want 00000004/00100093", wr_addr, wr_data); end
    tick();
    checks++; if ({done, wr_en, cpu_hold, busy, overflow} !== 5'b10100) begin
      errors++; $display("FAIL basic_done got %b want 10100", {done, wr_en, cpu_hold, busy, overflow}); end
    tick();
    checks++; if ({done, cpu_hold, busy} !== 3'b000) begin
      errors++; $display("FAIL basic_release got %b want 000", {done, cpu_hold, busy}); end
    checks++; if (wa_q.size() != 2) begin
      errors++; $display("FAIL basic_count got %0d want 2", wa_q.size()); end
    else begin
      checks++; if (wa_q[0] !== 32'h0 || wd_q[0] !== 32'h00500013) begin
        errors++; $display("FAIL basic_wr1 got %h/%h want 00000000/00500013", wa_q[0], wd_q[0]); end
    end
  endtask

  task automatic test_gaps();
    bit ok;
    stim[0] = 32'h00500113; stim[1] = 32'h00A00193; stim[2] = 32'h002081B3; stim[3] = 32'h40110233;
    stim[4] = 32'h00000297; stim[5] = 32'h0042A303; stim[6] = 32'hFE0318E3; stim[7] = 32'h0000006F;
    for (int run = 0; run < 2; run++) begin
      clear_queues();
      pulse_start(1'b0, 16'd8);
      send_words(1'b0, 8, run == 1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL gaps_accept run %0d got timeout want accepted", run); end
      wait_done(1'b0, 5, ok);
      checks++; if (!ok) begin errors++; $display("FAIL gaps_done run %0d got no done want done", run); end
      tick();
      checks++; if (wa_q.size() != 8) begin
        errors++; $display("FAIL gaps_count run %0d got %0d want 8", run, wa_q.size()); end
      else begin
        for (int i = 0; i < 8; i++) begin
          checks++; if (wa_q[i] !== 32'(4 * i) || wd_q[i] !== stim[i]) begin
            errors++; $display("FAIL gaps_wr run %0d word %0d got %h/%h want %h/%h", run, i, wa_q[i], wd_q[i], 32'(4 * i), stim[i]); end
        end
      end
    end
    checks++; if (rdy_in_write != 0) begin
      errors++; $display("FAIL ready_in_write got %0d want 0", rdy_in_write); end
  endtask

  task automatic test_zero_count();
    clear_queues();
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL zero_pre_hold got %b want 0", cpu_hold); end
    byte_valid = 1'b1;
    byte_data  = 8'hEE;
    pulse_start(1'b0, 16'd0);
    checks++; if ({done, cpu_hold, busy, byte_ready, wr_en} !== 5'b11000) begin
      errors++; $display("FAIL zero_done got %b want 11000", {done, cpu_hold, busy, byte_ready, wr_en}); end
    tick();
    checks++; if ({done, cpu_hold} !== 2'b00) begin
      errors++; $display("FAIL zero_release got %b want 00", {done, cpu_hold}); end
    tick();
    byte_valid = 1'b0;
    checks++; if (wa_q.size() != 0) begin errors++; $display("FAIL zero_writes got %0d want 0", wa_q.size()); end
  endtask

  task automatic test_overflow();
    bit ok;
    clear_queues();
    stim[0] = 32'h03020100; stim[1] = 32'h07060504; stim[2] = 32'h0B0A0908; stim[3] = 32'h0F0E0D0C;
    pulse_start(1'b1, 16'd6);
    checks++; if ({overflow4, busy4} !== 2'b11) begin
      errors++; $display("FAIL ovf_start got %b want 11", {overflow4, busy4}); end
    send_words(1'b1, 4, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_accept got timeout want accepted"); end
    checks++; if (wr_en4 !== 1'b1 || wr_addr4 !== 32'hC || wr_data4 !== 32'h0F0E0D0C) begin
      errors++; $display("FAIL ovf_last got %b/%h/%h want 1/0000000c/0f0e0d0c", wr_en4, wr_addr4, wr_data4); end
    tick();
    checks++; if (done4 !== 1'b1) begin errors++; $display("FAIL ovf_done got %b want 1", done4); end
    send_byte(1'b1, 8'h10, 10, ok);
    byte_valid = 1'b0;
    checks++; if (ok) begin errors++; $display("FAIL ovf_surplus got accepted want unaccepted"); end
    checks++; if ({byte_ready4, overflow4, busy4} !== 3'b010) begin
      errors++; $display("FAIL ovf_after got %b want 010", {byte_ready4, overflow4, busy4}); end
    checks++; if (wa4_q.size() != 4 || wa_q.size() != 0) begin
      errors++; $display("FAIL ovf_count got %0d/%0d want 4/0", wa4_q.size(), wa_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (wa4_q[i] !== 32'(4 * i) || wd4_q[i] !== stim[i]) begin
          errors++; $display("FAIL ovf_wr word %0d got %h/%h want %h/%h", i, wa4_q[i], wd4_q[i], 32'(4 * i), stim[i]); end
      end
    end
  endtask

  task automatic test_midload_reset();
    bit ok;
    clear_queues();
    pulse_start(1'b0, 16'd3);
    send_byte(1'b0, 8'hAA, 10, ok);
    send_byte(1'b0, 8'hBB, 10, ok);
    byte_valid = 1'b0;
    rst = 1'b1;
    tick();
    checks++; if ({byte_ready, wr_en, cpu_hold, busy, done, overflow} !== 6'b0 || {wr_addr, wr_data} !== 64'h0) begin
      errors++; $display("FAIL rst_mid got %b/%h want 000000/0", {byte_ready, wr_en, cpu_hold, busy, done, overflow}, {wr_addr, wr_data}); end
    rst = 1'b0;
    tick();
    stim[0] = 32'h44332211;
    pulse_start(1'b0, 16'd1);
    send_words(1'b0, 1, 1'b0, ok);
    checks++; if (wr_en !== 1'b1 || wr_addr !== 32'h0 || wr_data !== 32'h44332211) begin
      errors++; $display("FAIL rst_reload got %b/%h/%h want 1/00000000/44332211", wr_en, wr_addr, wr_data); end
    wait_done(1'b0, 5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_reload_done got no done want done"); end
    tick();
  endtask

  task automatic test_start_ignored();
    bit ok;
    logic [7:0] rest [0:6];
    clear_queues();
    rest[0] = 8'hBE; rest[1] = 8'hAD; rest[2] = 8'hDE;
    rest[3] = 8'h67; rest[4] = 8'h45; rest[5] = 8'h23; rest[6] = 8'h01;
    pulse_start(1'b0, 16'd2);
    send_byte(1'b0, 8'hEF, 10, ok);
    byte_valid = 1'b0;
    pulse_start(1'b0, 16'd5);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy got %b want 1", busy); end
    for (int i = 0; i < 7; i++) send_byte(1'b0, rest[i], 10, ok);
    byte_valid = 1'b0;
    wait_done(1'b0, 5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ign_done got no done want done"); end
    tick();
    checks++; if ({busy, byte_ready, cpu_hold} !== 3'b000) begin
      errors++; $display("FAIL ign_idle got %b want 000", {busy, byte_ready, cpu_hold}); end
    checks++; if (wd_q.size() != 2) begin errors++; $display("FAIL ign_count got %0d want 2", wd_q.size()); end
    else begin
      checks++; if (wd_q[0] !== 32'hDEADBEEF || wd_q[1] !== 32'h01234567 || wa_q[1] !== 32'h4) begin
        errors++; $display("FAIL ign_data got %h/%h@%h want deadbeef/01234567@00000004", wd_q[0], wd_q[1], wa_q[1]); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_queues();
    stim[0] = 32'hCAFEF00D;
    pulse_start(1'b0, 16'd1);
    send_words(1'b0, 1, 1'b0, ok);
    wait_done(1'b0, 5, ok);
    tick();
    stim[0] = 32'h8BADF00D;
    pulse_start(1'b0, 16'd1);
    send_words(1'b0, 1, 1'b0, ok);
    wait_done(1'b0, 5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_done got no done want done"); end
    tick();
    checks++; if (wd_q.size() != 2) begin errors++; $display("FAIL b2b_count got %0d want 2", wd_q.size()); end
    else begin
      checks++; if (wd_q[0] !== 32'hCAFEF00D || wd_q[1] !== 32'h8BADF00D || wa_q[1] !== 32'h0) begin
        errors++; $display("FAIL b2b_data got %h/%h@%h want cafef00d/8badf00d@00000000", wd_q[0], wd_q[1], wa_q[1]); end
    end
    // Overflowing load on the small instance, then a legal one right after.
    stim[0] = 32'h03020100; stim[1] = 32'h07060504; stim[2] = 32'h0B0A0908; stim[3] = 32'h0F0E0D0C;
    pulse_start(1'b1, 16'd5);
    checks++; if (overflow4 !== 1'b1) begin errors++; $display("FAIL b2b_ovf_set got %b want 1", overflow4); end
    send_words(1'b1, 4, 1'b0, ok);
    wait_done(1'b1, 5, ok);
    tick();
    checks++; if (overflow4 !== 1'b1) begin errors++; $display("FAIL b2b_ovf_sticky got %b want 1", overflow4); end
    stim[0] = 32'h12345678;
    pulse_start(1'b1, 16'd1);
    checks++; if (overflow4 !== 1'b0) begin errors++; $display("FAIL b2b_ovf_clear got %b want 0", overflow4); end
    send_words(1'b1, 1, 1'b0, ok);
    checks++; if (wr_en4 !== 1'b1 || wr_addr4 !== 32'h0 || wr_data4 !== 32'h12345678) begin
      errors++; $display("FAIL b2b_small got %b/%h/%h want 1/00000000/12345678", wr_en4, wr_addr4, wr_data4); end
    wait_done(1'b1, 5, ok);
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_zero_count();
    test_overflow();
    test_midload_reset();
    test_start_ignored();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
